// File: rtl/fp16_pkg.sv
// FP16 (1/5/10) constants, FSM state type and an unpack helper shared by
// the accumulator and its alignment stage.
package fp16_pkg;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_NINF = 16'hFC00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;   // hidden bit prepended
  } fp16_unp_t;

  // exp==0 is flushed to a zero significand (no subnormal support).
  function automatic fp16_unp_t fp16_unpack(input logic [15:0] v);
    fp16_unp_t u;
    u.sign = v[15];
    u.exp  = v[14:10];
    u.sig  = (v[14:10] == '0) ? '0 : {1'b1, v[9:0]};
    return u;
  endfunction
endpackage

// File: rtl/fp16_dot_acc_if.sv
// Handshake bundle between the product source and fp16_dot_acc.
//   start/len        : begin a dot product of len elements
//   in_valid/in_ready/in_data : product stream
//   out_valid/out_data: one-cycle result pulse, data held until next start
//   busy             : accumulator not idle
interface fp16_dot_acc_if #(parameter int LEN_W = 8);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic [15:0]      out_data;
  logic             busy;

  modport master (output start, len, in_valid, in_data,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  start, len, in_valid, in_data,
                  output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/fp16_align.sv
// Combinational ALIGN stage: swap so A is the larger magnitude, shift B right
// by the exponent difference (capped at 14) keeping guard/round/sticky, and
// detect inf/NaN operands.
//   i_acc, i_op        : raw FP16 accumulator and operand
//   o_sign_a, o_sub    : result sign and effective-subtract flag
//   o_exp              : exponent of A
//   o_sig_a, o_sig_b   : significands, B already aligned
//   o_grs              : guard, round, sticky from B's shift
//   o_special/o_spec_val : inf/NaN override value
module fp16_align
  import fp16_pkg::*;
(
  input  logic [15:0]      i_acc,
  input  logic [15:0]      i_op,
  output logic             o_sign_a,
  output logic             o_sub,
  output logic [EXP_W-1:0] o_exp,
  output logic [MAN_W:0]   o_sig_a,
  output logic [MAN_W:0]   o_sig_b,
  output logic [2:0]       o_grs,
  output logic             o_special,
  output logic [15:0]      o_spec_val
);
  fp16_unp_t   w_x, w_y, w_a, w_b;
  logic [4:0]  w_diff;
  logic [3:0]  w_sh;
  logic [26:0] w_ext;
  logic        w_x_inf, w_y_inf, w_x_nan, w_y_nan;

  always_comb begin
    w_x = fp16_unpack(i_acc);
    w_y = fp16_unpack(i_op);
    if ({w_y.exp, w_y.sig} > {w_x.exp, w_x.sig}) begin
      w_a = w_y; w_b = w_x;
    end else begin
      w_a = w_x; w_b = w_y;
    end
    w_diff = w_a.exp - w_b.exp;
    w_sh   = (w_diff > 5'd14) ? 4'd14 : w_diff[3:0];
    // 16 zero bits below B catch the whole 14-bit shift, so no bit is lost
    w_ext  = {w_b.sig, 16'h0000} >> w_sh;

    o_sign_a = w_a.sign;
    o_sub    = w_a.sign ^ w_b.sign;
    o_exp    = w_a.exp;
    o_sig_a  = w_a.sig;
    o_sig_b  = w_ext[26:16];
    o_grs    = {w_ext[15], w_ext[14], |w_ext[13:0]};

    w_x_inf = (i_acc[14:10] == 5'h1F) && (i_acc[9:0] == '0);
    w_y_inf = (i_op[14:10]  == 5'h1F) && (i_op[9:0]  == '0);
    w_x_nan = (i_acc[14:10] == 5'h1F) && (i_acc[9:0] != '0);
    w_y_nan = (i_op[14:10]  == 5'h1F) && (i_op[9:0]  != '0);

    o_special = w_x_inf | w_y_inf | w_x_nan | w_y_nan;
    // acc itself is NaN once poisoned, so NaN stays sticky without extra state
    if (w_x_nan | w_y_nan | (w_x_inf & w_y_inf & (i_acc[15] ^ i_op[15])))
      o_spec_val = FP16_QNAN;
    else if (w_x_inf)
      o_spec_val = i_acc[15] ? FP16_NINF : FP16_PINF;
    else if (w_y_inf)
      o_spec_val = i_op[15] ? FP16_NINF : FP16_PINF;
    else
      o_spec_val = FP16_ZERO;
  end
endmodule

// File: rtl/fp16_dot_acc.sv
// Multi-cycle FP16 accumulator for a stream of products.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fp16_dot_acc_if (start/len, product stream,
//              result pulse, busy)
// Each element runs WAIT -> ALIGN -> ADD -> NORM -> ROUND; after the last
// element DONE registers the result and pulses out_valid.
module fp16_dot_acc
  import fp16_pkg::*;
#(
  parameter int LEN_W = 8
)(
  input logic           clk,
  input logic           rst,
  fp16_dot_acc_if.slave bus
);
  state_t             r_state, w_state_nxt;
  logic [15:0]        r_acc, r_op, r_out_data, r_spec_val;
  logic [LEN_W-1:0]   r_count;
  logic               r_out_valid, r_sign, r_sub, r_special;
  logic signed [6:0]  r_exp;
  logic [MAN_W:0]     r_sig_a, r_sig_b;
  logic [2:0]         r_grs;
  logic [14:0]        r_mag;
  logic               w_in_ready, w_busy;

  logic               w_sign_a, w_sub, w_special, w_inc;
  logic [EXP_W-1:0]   w_exp;
  logic [MAN_W:0]     w_sig_a, w_sig_b;
  logic [2:0]         w_grs;
  logic [15:0]        w_spec_val, w_round_res;
  logic [14:0]        w_sum, w_nmag;
  logic [3:0]         w_lz;
  logic signed [6:0]  w_nexp, w_rexp;
  logic [11:0]        w_rsig;

  fp16_align u_align (
    .i_acc(r_acc), .i_op(r_op),
    .o_sign_a(w_sign_a), .o_sub(w_sub), .o_exp(w_exp),
    .o_sig_a(w_sig_a), .o_sig_b(w_sig_b), .o_grs(w_grs),
    .o_special(w_special), .o_spec_val(w_spec_val)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = (bus.len == '0) ? S_DONE : S_WAIT;
      S_WAIT: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_ALIGN;
      end
      S_ALIGN: w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_ROUND;
      S_ROUND: w_state_nxt = (r_count == LEN_W'(1)) ? S_DONE : S_WAIT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: 15-bit magnitude = {carry, hidden, 10 mantissa, g, r, s}
  always_comb begin
    w_sum = r_sub ? ({1'b0, r_sig_a, 3'b000} - {1'b0, r_sig_b, r_grs})
                  : ({1'b0, r_sig_a, 3'b000} + {1'b0, r_sig_b, r_grs});
    w_lz = 4'd0;
    for (int i = 0; i <= 13; i++)
      if (r_mag[i]) w_lz = 4'(13 - i);
    if (r_mag[14]) begin
      w_nmag = {1'b0, r_mag[14:2], r_mag[1] | r_mag[0]};
      w_nexp = r_exp + 7'sd1;
    end else begin
      w_nmag = r_mag << w_lz;
      w_nexp = r_exp - $signed({3'b000, w_lz});
    end
    w_inc  = r_mag[2] & (r_mag[3] | r_mag[1] | r_mag[0]);
    w_rsig = {1'b0, r_mag[13:3]} + {11'h000, w_inc};
    w_rexp = r_exp + $signed({6'b000000, w_rsig[11]});
    if (r_special)
      w_round_res = r_spec_val;
    else if (w_rexp >= 7'sd31)
      w_round_res = r_sign ? FP16_NINF : FP16_PINF;
    else
      w_round_res = {r_sign, w_rexp[4:0], w_rsig[11] ? 10'h000 : w_rsig[9:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= FP16_ZERO; r_op <= '0; r_count <= '0;
      r_out_valid <= 1'b0; r_out_data <= FP16_ZERO;
      r_sign <= 1'b0; r_sub <= 1'b0; r_exp <= '0;
      r_sig_a <= '0; r_sig_b <= '0; r_grs <= '0; r_mag <= '0;
      r_special <= 1'b0; r_spec_val <= FP16_ZERO;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_acc   <= FP16_ZERO;
          r_count <= bus.len;
        end
        S_WAIT: if (bus.in_valid) r_op <= bus.in_data;
        S_ALIGN: begin
          r_sign <= w_sign_a; r_sub <= w_sub; r_exp <= 7'(w_exp);
          r_sig_a <= w_sig_a; r_sig_b <= w_sig_b; r_grs <= w_grs;
          r_special <= w_special; r_spec_val <= w_spec_val;
        end
        S_ADD: r_mag <= w_sum;
        S_NORM: begin
          r_mag <= w_nmag;
          r_exp <= w_nexp;
          // exact cancellation is +0; exponent underflow keeps the sign
          if (!r_special && r_mag == '0) begin
            r_special <= 1'b1; r_spec_val <= FP16_ZERO;
          end else if (!r_special && w_nexp <= 7'sd0) begin
            r_special <= 1'b1; r_spec_val <= {r_sign, 15'h0000};
          end
        end
        S_ROUND: begin
          r_acc   <= w_round_res;
          r_count <= r_count - LEN_W'(1);
        end
        S_DONE: begin
          r_out_data  <= r_acc;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_dot_acc.sv
module tb_fp16_dot_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp16_dot_acc_if #(.LEN_W(8)) bus();
  fp16_dot_acc #(.LEN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Stimulus helpers: inputs change and outputs are sampled on negedge.
  task automatic do_start(input logic [7:0] n);
    bus.start = 1'b1; bus.len = n;
    @(negedge clk);
    bus.start = 1'b0; bus.len = 8'd0;
  endtask

  // Returns on the negedge after the transfer edge; waited = negedges spent
  // with in_valid high before in_ready was seen.
  task automatic xfer(input logic [15:0] d, output int waited);
    bus.in_valid = 1'b1; bus.in_data = d; waited = 0;
    while (!bus.in_ready && waited < 40) begin @(negedge clk); waited++; end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_data = 16'h0000;
  endtask

  // lat = edges until out_valid is seen; extra = out_valid one cycle later
  task automatic wait_out(output logic [15:0] d, output int lat, output logic extra);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 40);
    d = bus.out_data;
    @(negedge clk);
    extra = bus.out_valid;
  endtask

  task automatic run_dot(input logic [7:0] n, input logic [15:0] v0, v1, v2,
                         output logic [15:0] res, output int lat, output int gap,
                         output logic extra);
    logic [15:0] v [3];
    int w;
    v[0] = v0; v[1] = v1; v[2] = v2; gap = 0;
    do_start(n);
    for (int i = 0; i < int'(n); i++) begin
      xfer(v[i], w);
      if (i > 0) gap = w;
    end
    wait_out(res, lat, extra);
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.len = 8'd0; bus.in_valid = 1'b0; bus.in_data = 16'h0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_sum;
    logic [15:0] r; int lat, gap; logic ex;
    // 4.0 + 4.0 = 8.0
    run_dot(8'd2, 16'h4400, 16'h4400, 16'h0000, r, lat, gap, ex);
    checks++; if (r !== 16'h4800) begin errors++; $display("FAIL basic_data: got %h want 4800", r); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
    checks++; if (gap !== 4) begin errors++; $display("FAIL basic_elem_gap: got %0d want 4", gap); end
    checks++; if (ex !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: out_valid %b want 0 on second cycle", ex); end
  endtask

  task automatic test_cancel;
    logic [15:0] r; int lat, gap; logic ex;
    // 1 - 1 + 2 = 2
    run_dot(8'd3, 16'h3C00, 16'hBC00, 16'h4000, r, lat, gap, ex);
    checks++; if (r !== 16'h4000) begin errors++; $display("FAIL cancel3: got %h want 4000", r); end
    // exact cancellation is +0
    run_dot(8'd2, 16'h3C00, 16'hBC00, 16'h0000, r, lat, gap, ex);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL cancel_zero: got %h want 0000", r); end
    // -2 + 1 = -1 (subtract with one-bit renormalize)
    run_dot(8'd2, 16'hC000, 16'h3C00, 16'h0000, r, lat, gap, ex);
    checks++; if (r !== 16'hBC00) begin errors++; $display("FAIL neg_sum: got %h want bc00", r); end
    // len=0: start sampled, DONE next cycle, out_valid the cycle after
    do_start(8'd0);
    wait_out(r, lat, ex);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL len0_data: got %h want 0000", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL len0_latency: got %0d want 1 after start edge", lat); end
    checks++; if (ex !== 1'b0) begin errors++; $display("FAIL len0_pulse_width: out_valid %b want 0", ex); end
  endtask

  task automatic test_rounding;
    logic [15:0] r; int lat, gap; logic ex;
    // 1 + 2^-11 is a tie, mantissa even -> stays 1.0
    run_dot(8'd2, 16'h3C00, 16'h1000, 16'h0000, r, lat, gap, ex);
    checks++; if (r !== 16'h3C00) begin errors++; $display("FAIL round_tie_even: got %h want 3c00", r); end
    // odd mantissa tie rounds up
    run_dot(8'd2, 16'h3C01, 16'h1000, 16'h0000, r, lat, gap, ex);
    checks++; if (r !== 16'h3C02) begin errors++; $display("FAIL round_tie_up: got %h want 3c02", r); end
  endtask

  task automatic test_specials;
    logic [15:0] r; int lat, gap; logic ex;
    run_dot(8'd2, 16'h7BFF, 16'h7BFF, 16'h0000, r, lat, gap, ex);
    checks++; if (r !== 16'h7C00) begin errors++; $display("FAIL overflow_inf: got %h want 7c00", r); end
    run_dot(8'd2, 16'h7C00, 16'hFC00, 16'h0000, r, lat, gap, ex);
    checks++; if (r !== 16'h7E00) begin errors++; $display("FAIL inf_minus_inf: got %h want 7e00", r); end
    run_dot(8'd2, 16'h7E00, 16'h3C00, 16'h0000, r, lat, gap, ex);
    checks++; if (r !== 16'h7E00) begin errors++; $display("FAIL nan_sticky: got %h want 7e00", r); end
    run_dot(8'd2, 16'hFC00, 16'h3C00, 16'h0000, r, lat, gap, ex);
    checks++; if (r !== 16'hFC00) begin errors++; $display("FAIL inf_plus_finite: got %h want fc00", r); end
  endtask

  task automatic test_handshake;
    logic [15:0] r; int lat, w; logic ex; logic rdy_ok;
    do_start(8'd2);
    rdy_ok = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (bus.in_ready !== 1'b1) rdy_ok = 1'b0;
      @(negedge clk);
    end
    checks++; if (rdy_ok !== 1'b1) begin errors++; $display("FAIL stall_in_ready: ready_held=%b want 1", rdy_ok); end
    xfer(16'h4400, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL stall_first_wait: got %0d want 0", w); end
    // now in ALIGN: start pulse and junk data while not ready
    bus.start = 1'b1; bus.len = 8'd0; bus.in_valid = 1'b1; bus.in_data = 16'h7E00;
    @(negedge clk);
    bus.start = 1'b0; bus.in_data = 16'hFC00;
    @(negedge clk);
    bus.in_data = 16'h7BFF;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL start_ignored: busy=%b out_valid=%b want 1/0", bus.busy, bus.out_valid); end
    xfer(16'h4400, w);
    checks++; if (w !== 1) begin errors++; $display("FAIL stall_second_wait: got %0d want 1", w); end
    wait_out(r, lat, ex);
    checks++; if (r !== 16'h4800) begin errors++; $display("FAIL stall_data: got %h want 4800", r); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL stall_latency: got %0d want 5", lat); end
  endtask

  task automatic test_reset_midop;
    logic [15:0] r; int lat, gap, w; logic ex; logic seen;
    do_start(8'd3);
    xfer(16'h3C00, w);     // now in ALIGN
    @(negedge clk);        // now in ADD
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL midrst_out_data: got %h want 0000", bus.out_data); end
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_pulse: pulse_seen=%b want 0", seen); end
    run_dot(8'd1, 16'h4000, 16'h0000, 16'h0000, r, lat, gap, ex);
    checks++; if (r !== 16'h4000) begin errors++; $display("FAIL midrst_restart: got %h want 4000", r); end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_cancel();
    test_rounding();
    test_specials();
    test_handshake();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
